imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate/operand extender for the MIPS datapath.
- Generalises the plain 16→32 combinational sign-extender: configurable widths, five extension modes (sign, zero, upper/LUI, byte sign, byte zero) and an ordered tag.
- Sits between decode and the execute operand mux, behind a valid/ready handshake with a 2-entry output skid buffer, so execute-side stalls never drop or reorder operands.

Parameters:
- IN_W, 16, input immediate width; legal range 8 ≤ IN_W < OUT_W.
- OUT_W, 32, extended output width.
- TAG_W, 5, width of the sideband tag carried with each operand (e.g. destination register number).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has an operand.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  IN_W  raw immediate.
- in_mode  input  3  extension mode, encoded as follows.
  - 0 = SEXT.
  - 1 = ZEXT.
  - 2 = UPPER.
  - 3 = SEXT_B.
  - 4 = ZEXT_B.
  - 5-7 illegal.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  out_data/out_tag/out_err valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  extended value.
- out_tag  output  TAG_W  tag of the operand in out_data.
- out_err  output  1  operand had an illegal mode; out_data forced to 0.

Behaviour:
- Reset (rst_n low, async): both buffer entries invalid. out_valid=0, out_data=0, out_tag=0, out_err=0, in_ready=1. State is also cleared mid-transfer; any in-flight operands are discarded.
- Input handshake: transfer when in_valid && in_ready. Output handshake: transfer when out_valid && out_ready.
- Extension rules are computed combinationally on input and registered on accept:
  - SEXT: replicate in_data[IN_W-1] into the upper OUT_W-IN_W bits.
  - ZEXT: zero-fill the upper bits.
  - UPPER: in_data placed at bits [OUT_W-1:OUT_W-IN_W], low bits 0. At 16/32 this is LUI.
  - SEXT_B: replicate in_data[7] over bits [OUT_W-1:8].
  - ZEXT_B: zero-fill bits [OUT_W-1:8].
  - Modes 5-7: out_data=0, out_err=1. The tag is still passed through and no operand is dropped.
- Latency: exactly 1 cycle from input handshake to out_valid when the buffer is empty. Throughput is 1 operand per cycle while out_ready stays high.
- Buffer: 2 entries, head (drives outputs) and skid.
  - State EMPTY: in_ready=1, out_valid=0. An accept moves to ONE.
  - State ONE: in_ready=1, out_valid=1.
    - Accept with no drain: go to FULL.
    - Drain with no accept: go to EMPTY.
    - Accept and drain in the same cycle: stay in ONE, and the head is loaded with the new operand.
  - State FULL: in_ready=0, out_valid=1.
    - A drain moves the skid entry to the head and goes to ONE.
    - No accept can occur in FULL.
- in_ready is a registered output: it depends only on state, never combinationally on out_ready.
- Ordering is strict FIFO; tags leave in acceptance order.
- Outputs hold stable while out_valid && !out_ready.
- Elaboration: if IN_W < 8 or IN_W ≥ OUT_W, the block emits $error at elaboration.

Optional Feature:
- Macro IMM_EXTEND_STATS_EN.
- When defined, the block adds two outputs:
  - stat_count, 32 bits: counts output handshakes.
  - stat_err, 16 bits: counts output handshakes with out_err=1; saturates at 16'hFFFF.
  - Both counters reset to 0 on rst_n and wrap/saturate as stated.
- When undefined, neither port nor the counter logic exists, and the rest of the behaviour is identical.

Test Plan:
- Reset then single SEXT: in_data=16'h8001, tag=3, out_ready=1 → next cycle out_valid=1, out_data=32'hFFFF8001, out_tag=3, out_err=0.
- All modes back-to-back, in_data=16'h1280, out_ready=1 → outputs are 0x00001280, 0x00001280, 0x12800000, 0xFFFFFF80, 0x00000080 on consecutive cycles, no bubbles.
- Backpressure: out_ready=0, issue tags 1, 2, 3.
  - After 2 accepts, in_ready=0 and tag 3 is held upstream.
  - Raise out_ready → tags emerge 1, 2, 3 in order; none lost or duplicated.
- Simultaneous accept and drain in ONE, over 20 cycles with streaming input and out_ready=1 → in_ready stays 1 and every operand appears exactly once, 1 cycle late.
- Illegal mode 6, in_data=16'hFFFF, tag=7 → out_data=0, out_err=1, out_tag=7. The next legal operand has out_err=0.
- Async reset asserted mid-cycle while FULL → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge. With IMM_EXTEND_STATS_EN defined, stat_count=0 and stat_err=0.

Source files
------------

// File: rtl/imm_extend_if.sv
// Handshake bundle for imm_extend_pipe: decode-side operand channel and execute-side result channel.
// master = surrounding pipeline (drives operands, accepts results); slave = the extender.
interface imm_extend_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [2:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry skid buffer (head + skid) behind valid/ready.
// Optional IMM_EXTEND_STATS_EN adds handshake/error counters stat_count and stat_err.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IMM_EXTEND_STATS_EN
  output logic [31:0] stat_count,
  output logic [15:0] stat_err,
`endif
  imm_extend_if.slave bus
);

  if (IN_W < 8 || IN_W >= OUT_W) begin : g_bad_width
    $error("imm_extend_pipe: IN_W must satisfy 8 <= IN_W < OUT_W");
  end

  localparam logic [2:0] ModeSext  = 3'd0;
  localparam logic [2:0] ModeZext  = 3'd1;
  localparam logic [2:0] ModeUpper = 3'd2;
  localparam logic [2:0] ModeSextB = 3'd3;
  localparam logic [2:0] ModeZextB = 3'd4;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d, skid_tag_q, skid_tag_d;
  logic             head_err_q, head_err_d, skid_err_q, skid_err_d;

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             accept;
  logic             drain;

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (bus.in_mode)
      ModeSext:  ext_data = {{(OUT_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
      ModeZext:  ext_data = {{(OUT_W-IN_W){1'b0}}, bus.in_data};
      ModeUpper: ext_data = {bus.in_data, {(OUT_W-IN_W){1'b0}}};
      ModeSextB: ext_data = {{(OUT_W-8){bus.in_data[7]}}, bus.in_data[7:0]};
      ModeZextB: ext_data = {{(OUT_W-8){1'b0}}, bus.in_data[7:0]};
      default:   ext_err  = 1'b1;
    endcase
  end

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_data_d = ext_data;
          head_tag_d  = bus.in_tag;
          head_err_d  = ext_err;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          head_data_d = ext_data;
          head_tag_d  = bus.in_tag;
          head_err_d  = ext_err;
        end else if (accept) begin
          skid_data_d = ext_data;
          skid_tag_d  = bus.in_tag;
          skid_err_d  = ext_err;
          state_d     = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          head_data_d = skid_data_q;
          head_tag_d  = skid_tag_q;
          head_err_d  = skid_err_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    in_ready_d  = (state_d != StFull);
    out_valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_data_q <= '0;
      head_tag_q  <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      head_err_q  <= head_err_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_data_q;
  assign bus.out_tag   = head_tag_q;
  assign bus.out_err   = head_err_q;

`ifdef IMM_EXTEND_STATS_EN
  logic [31:0] stat_count_q, stat_count_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_count_d = stat_count_q;
    stat_err_d   = stat_err_q;
    if (drain) begin
      stat_count_d = stat_count_q + 32'd1;
      if (head_err_q && (stat_err_q != 16'hFFFF)) begin
        stat_err_d = stat_err_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_count_q <= '0;
      stat_err_q   <= '0;
    end else begin
      stat_count_q <= stat_count_d;
      stat_err_q   <= stat_err_d;
    end
  end

  assign stat_count = stat_count_q;
  assign stat_err   = stat_err_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: mode table, backpressure, streaming and async reset.
module tb_imm_extend_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  imm_extend_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();

`ifdef IMM_EXTEND_STATS_EN
  logic [31:0] stat_count;
  logic [15:0] stat_err;
`endif

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef IMM_EXTEND_STATS_EN
    .stat_count (stat_count),
    .stat_err   (stat_err),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] data;
    logic [4:0]  tag;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] d,
                       input logic [4:0] t);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_data  = d;
    bus.in_tag   = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{3'd0, 16'h8001, 5'd3,  32'hFFFF8001, 1'b0};
    vecs[1]  = '{3'd0, 16'h1280, 5'd4,  32'h00001280, 1'b0};
    vecs[2]  = '{3'd1, 16'h1280, 5'd5,  32'h00001280, 1'b0};
    vecs[3]  = '{3'd2, 16'h1280, 5'd6,  32'h12800000, 1'b0};
    vecs[4]  = '{3'd3, 16'h1280, 5'd8,  32'hFFFFFF80, 1'b0};
    vecs[5]  = '{3'd4, 16'h1280, 5'd9,  32'h00000080, 1'b0};
    vecs[6]  = '{3'd6, 16'hFFFF, 5'd7,  32'h00000000, 1'b1};
    vecs[7]  = '{3'd0, 16'h7FFF, 5'd10, 32'h00007FFF, 1'b0};
    vecs[8]  = '{3'd1, 16'h8001, 5'd11, 32'h00008001, 1'b0};
    vecs[9]  = '{3'd2, 16'hFFFF, 5'd12, 32'hFFFF0000, 1'b0};
    vecs[10] = '{3'd3, 16'h127F, 5'd13, 32'h0000007F, 1'b0};
    vecs[11] = '{3'd4, 16'h12FF, 5'd14, 32'h000000FF, 1'b0};
    vecs[12] = '{3'd5, 16'h1234, 5'd31, 32'h00000000, 1'b1};
    vecs[13] = '{3'd7, 16'h0001, 5'd0,  32'h00000000, 1'b1};

    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_out_tag",   32'(bus.out_tag),   32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;

    // Back-to-back table: each vector must appear exactly one cycle after it is offered.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].data, vecs[i].tag);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  bus.out_data,       vecs[i].exp);
      chk($sformatf("vec%0d_tag", i),   32'(bus.out_tag),   32'(vecs[i].tag));
      chk($sformatf("vec%0d_err", i),   32'(bus.out_err),   32'(vecs[i].err));
      chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready),  32'd1);
    end
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    tick();
    chk("table_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: two entries fill, third operand waits upstream.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h8001, 5'd1);
    tick();
    chk("bp1_ready", 32'(bus.in_ready), 32'd1);
    chk("bp1_tag",   32'(bus.out_tag),  32'd1);
    drive(1'b1, 3'd0, 16'h8002, 5'd2);
    tick();
    chk("bp2_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2_tag",   32'(bus.out_tag),  32'd1);
    chk("bp2_data",  bus.out_data,      32'hFFFF8001);
    drive(1'b1, 3'd0, 16'h8003, 5'd3);
    tick();
    chk("bp3_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3_hold",  32'(bus.out_tag),  32'd1);
    chk("bp3_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out2_tag",  32'(bus.out_tag), 32'd2);
    chk("bp_out2_data", bus.out_data,     32'hFFFF8002);
    chk("bp_out2_rdy",  32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_out3_tag",  32'(bus.out_tag), 32'd3);
    chk("bp_out3_data", bus.out_data,     32'hFFFF8003);
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    tick();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Streaming: accept and drain together every cycle while in ONE.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] d;
      d = 16'h0F0F ^ 16'(i * 32'h1357);
      drive(1'b1, 3'd0, d, 5'(i));
      tick();
      chk($sformatf("st%0d_ready", i), 32'(bus.in_ready),  32'd1);
      chk($sformatf("st%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("st%0d_tag", i),   32'(bus.out_tag),   32'(i));
      chk($sformatf("st%0d_data", i),  bus.out_data,       {{16{d[15]}}, d});
    end
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    tick();
    chk("st_empty", 32'(bus.out_valid), 32'd0);

    // Fill to FULL, then assert reset between clock edges.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd1, 16'h00AA, 5'd9);
    tick();
    drive(1'b1, 3'd1, 16'h00BB, 5'd10);
    tick();
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    chk("full_ready", 32'(bus.in_ready),  32'd0);
    chk("full_valid", 32'(bus.out_valid), 32'd1);
`ifdef IMM_EXTEND_STATS_EN
    chk("stat_count", stat_count,      32'd37);
    chk("stat_err",   32'(stat_err),   32'd3);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_ready", 32'(bus.in_ready),  32'd1);
    chk("arst_tag",   32'(bus.out_tag),   32'd0);
    chk("arst_data",  bus.out_data,       32'd0);
`ifdef IMM_EXTEND_STATS_EN
    chk("arst_stat_count", stat_count,    32'd0);
    chk("arst_stat_err",   32'(stat_err), 32'd0);
`endif
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd2, 16'hABCD, 5'd21);
    tick();
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    chk("post_rst_data", bus.out_data,     32'hABCD0000);
    chk("post_rst_tag",  32'(bus.out_tag), 32'd21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
